// File: rtl/nor2_bist_ctrl.sv
// -----------------------------------------------------------------------------
// nor2_bist_ctrl
//   Built-in self-test sequencer for one 2-input NOR gate instance. A run
//   drives the four input vectors 00,01,10,11 onto the gate pins. Each vector
//   is held for SETTLE_CYCLES cycles and then sampled for one cycle. The sampled
//   gate output is compared with the expected NOR value. A run is PASSES full
//   sweeps long. At the end the block pulses done, publishes a pass flag, and
//   holds a saturating mismatch count until the next accepted start.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before its sample cycle (>= 1)
//   PASSES         number of 4-vector sweeps per run (>= 1)
//   ERR_W          width of err_count_o, saturates at 2^ERR_W-1
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      run request, only looked at while idle
//   dut_a_o      gate input a (registered)
//   dut_b_o      gate input b (registered)
//   dut_o_i      gate output under test, only looked at in the sample cycle
//   busy_o       high while the run is sweeping vectors
//   done_o       one-cycle pulse at the end of a run
//   pass_o       last run had zero mismatches
//   err_count_o  mismatches in the last run (saturating)
//   fail_vec_o   (only with NOR2_BIST_LOG_EN) sticky per-vector mismatch mask
//
// Build option
//   NOR2_BIST_LOG_EN  when defined, adds fail_vec_o and its logging logic.
// -----------------------------------------------------------------------------
module nor2_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             dut_a_o,
  output logic             dut_b_o,
  input  logic             dut_o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o
`ifdef NOR2_BIST_LOG_EN
  ,
  output logic [3:0]       fail_vec_o
`endif
);

  localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PW = (PASSES < 2) ? 1 : $clog2(PASSES);

  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(1);
  localparam logic [PW-1:0]    LAST_PASS   = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Expected gate response for the vector currently on the pins.
  function automatic logic nor_expect(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // Mismatch counter increment that sticks at the all-ones value.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    if (cnt == ERR_MAX) begin
      return cnt;
    end else begin
      return cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
`ifdef NOR2_BIST_LOG_EN
  logic [3:0]       fail_q, fail_d;
`endif

  logic             last_vec_s;
  logic             last_pass_s;
  logic             mismatch_s;

  assign last_vec_s  = (vec_q == 2'd3);
  assign last_pass_s = (pcnt_q == LAST_PASS);
  // Compare against the registered pins: that is exactly what the gate sees.
  assign mismatch_s  = (dut_o_i != nor_expect(a_q, b_q));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SAMPLE: begin
        if (last_vec_s && last_pass_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; busy/done are derived from the next
  // state so that the registered copies line up with the state they describe.
  always_comb begin
    vec_d    = vec_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    a_d      = a_q;
    b_d      = b_q;
`ifdef NOR2_BIST_LOG_EN
    fail_d   = fail_q;
`endif
    busy_d   = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d   = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vec_d    = 2'd0;
          pcnt_d   = {PW{1'b0}};
          err_d    = ERR_ZERO;
          pass_d   = 1'b0;
          settle_d = SETTLE_LOAD;
          a_d      = 1'b0;
          b_d      = 1'b0;
`ifdef NOR2_BIST_LOG_EN
          fail_d   = 4'b0000;
`endif
        end else begin
          vec_d    = vec_q;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - SETTLE_LAST;
      end
      S_SAMPLE: begin
        if (mismatch_s) begin
          err_d = sat_inc(err_q);
`ifdef NOR2_BIST_LOG_EN
          fail_d[vec_q] = 1'b1;
`endif
        end else begin
          err_d = err_q;
        end

        if (!last_vec_s) begin
          vec_d    = vec_q + 2'd1;
          settle_d = SETTLE_LOAD;
          {a_d, b_d} = vec_q + 2'd1;
        end else if (!last_pass_s) begin
          vec_d    = 2'd0;
          pcnt_d   = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
          settle_d = SETTLE_LOAD;
          a_d      = 1'b0;
          b_d      = 1'b0;
        end else begin
          // Final sample: the verdict must include this cycle's mismatch.
          a_d      = 1'b0;
          b_d      = 1'b0;
          pass_d   = (err_d == ERR_ZERO);
        end
      end
      S_DONE: begin
        vec_d = vec_q;
      end
      default: begin
        vec_d = 2'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q    <= 2'd0;
      settle_q <= {SW{1'b0}};
      pcnt_q   <= {PW{1'b0}};
      err_q    <= ERR_ZERO;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
`ifdef NOR2_BIST_LOG_EN
      fail_q   <= 4'b0000;
`endif
    end else begin
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifdef NOR2_BIST_LOG_EN
      fail_q   <= fail_d;
`endif
    end
  end

  assign dut_a_o     = a_q;
  assign dut_b_o     = b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
`ifdef NOR2_BIST_LOG_EN
  assign fail_vec_o  = fail_q;
`endif

endmodule

// File: tb/tb_nor2_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nor2_bist_ctrl
//   Two instances: A with default parameters, B with SETTLE_CYCLES=3,
//   PASSES=6. Each gate under test is a 4-entry truth table indexed by {a,b},
//   so any 2-input function (NOR, OR, stuck-at, random) can be attached.
//   Expected pin sequence, done cycle and result are computed from the run
//   timing rules and the truth-table mismatch mask against NOR.
// -----------------------------------------------------------------------------
module tb_nor2_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] lut_a = 4'b0001, lut_b = 4'b0001;
  logic       a_a, b_a, o_a, busy_a, done_a, pass_a;
  logic       a_b, b_b, o_b, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
`ifdef NOR2_BIST_LOG_EN
  logic [3:0] fv_a, fv_b;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  // Gate models: truth table indexed by {a,b}; NOR is 4'b0001.
  assign o_a = lut_a[{a_a, b_a}];
  assign o_b = lut_b[{a_b, b_b}];

  nor2_bist_ctrl u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
    .dut_a_o(a_a), .dut_b_o(b_a), .dut_o_i(o_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a)
`ifdef NOR2_BIST_LOG_EN
    , .fail_vec_o(fv_a)
`endif
  );

  nor2_bist_ctrl #(.SETTLE_CYCLES(3), .PASSES(6), .ERR_W(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .dut_a_o(a_b), .dut_b_o(b_b), .dut_o_i(o_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b)
`ifdef NOR2_BIST_LOG_EN
    , .fail_vec_o(fv_b)
`endif
  );

  logic       obs_busy, obs_done, obs_pass, obs_a, obs_b;
  logic [3:0] obs_err;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_pass = sel ? pass_b : pass_a;
  assign obs_a    = sel ? a_b    : a_a;
  assign obs_b    = sel ? b_b    : b_a;
  assign obs_err  = sel ? err_b  : err_a;
`ifdef NOR2_BIST_LOG_EN
  logic [3:0] obs_fv;
  assign obs_fv   = sel ? fv_b : fv_a;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run with a single-cycle start pulse. Entered and left 1 time unit
  // after a rising edge. Cycle 0 is the cycle in which start is high.
  task automatic run_one(input bit sel_i, input logic [3:0] lut, input int gap);
    int s_c, p_c, len, exp_err, idx;
    logic [3:0] mis;
    sel = sel_i;
    s_c = sel_i ? 3 : 1;
    p_c = sel_i ? 6 : 1;
    len = 4 * p_c * (s_c + 1) + 1;
    mis = lut ^ 4'b0001;
    exp_err = p_c * $countones(mis);
    if (exp_err > 15) exp_err = 15;
    if (sel_i) lut_b = lut; else lut_a = lut;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    if (sel_i) start_b = 1'b1; else start_a = 1'b1;
    for (int t = 0; t <= len + 1; t++) begin
      @(negedge clk);
      check($sformatf("busy t=%0d", t), 32'(obs_busy), 32'((t >= 1) && (t < len)));
      check($sformatf("done t=%0d", t), 32'(obs_done), 32'(t == len));
      if (t >= 1 && t < len) begin
        idx = ((t - 1) / (s_c + 1)) % 4;
        check($sformatf("pins t=%0d", t), 32'({obs_a, obs_b}), 32'(idx));
      end
      if (t == 1) begin
        check("err cleared", 32'(obs_err), 32'd0);
        check("pass cleared", 32'(obs_pass), 32'd0);
      end
      if (t >= len) begin
        check($sformatf("pins idle t=%0d", t), 32'({obs_a, obs_b}), 32'd0);
        check($sformatf("err t=%0d lut=%b", t, lut), 32'(obs_err), 32'(exp_err));
        check($sformatf("pass t=%0d lut=%b", t, lut), 32'(obs_pass), 32'(exp_err == 0));
`ifdef NOR2_BIST_LOG_EN
        check($sformatf("fail_vec t=%0d", t), 32'(obs_fv), 32'(mis));
`endif
      end
      @(posedge clk); #1;
      if (t == 0) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst pins", 32'({a_a, b_a}), 32'd0);
    check("rst err", 32'(err_a), 32'd0);
    check("rst pass", 32'(pass_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: correct NOR, stuck-at-0, OR gate.
    run_one(1'b0, 4'b0001, 0);
    run_one(1'b0, 4'b0000, 0);
    run_one(1'b0, 4'b1110, 0);
    // Directed: long configuration with stuck-at-1 saturating the count.
    run_one(1'b1, 4'b1111, 0);

    // Randomized gate functions and idle gaps.
    for (int i = 0; i < 6; i++) begin
      run_one(1'b0, 4'($urandom), int'($urandom_range(0, 3)));
    end
    run_one(1'b1, 4'($urandom), int'($urandom_range(0, 3)));

    // start held high for 20 cycles: runs at cycle 0 and cycle 10.
    sel = 1'b0;
    lut_a = 4'b0001;
    start_a = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      check($sformatf("held busy t=%0d", t), 32'(busy_a),
            32'(((t >= 1) && (t <= 8)) || ((t >= 11) && (t <= 18))));
      check($sformatf("held done t=%0d", t), 32'(done_a), 32'((t == 9) || (t == 19)));
      @(posedge clk); #1;
      if (t == 19) start_a = 1'b0;
    end

    // Reset in the settle phase of vector 10, stuck-at-0 gate so err is 1.
    lut_a = 4'b0000;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre-rst pins", 32'({a_a, b_a}), 32'b10);
    check("pre-rst err", 32'(err_a), 32'd1);
    check("pre-rst busy", 32'(busy_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async busy", 32'(busy_a), 32'd0);
    check("async pins", 32'({a_a, b_a}), 32'd0);
    check("async err", 32'(err_a), 32'd0);
    check("async pass", 32'(pass_a), 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check($sformatf("no done in rst t=%0d", t), 32'(done_a), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("no done after rst", 32'(done_a), 32'd0);
    @(posedge clk); #1;
    run_one(1'b0, 4'b0001, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
